error_tolerant_type2_sub32_pipe: RTL and testbench

Pipelined 32-bit error-tolerant (type-2, block-speculative) subtractor. It is the subtraction counterpart of the team's error-tolerant type-2 adder. It accepts operand pairs over a valid/ready stream and returns a 33-bit approximate difference two cycles later. It also flags each result that differs from the exact difference and keeps a saturating count of flagged results for accuracy characterisation.

---
 rtl/error_tolerant_type2_sub32_pipe.sv | 165 ++++++++++++++++
 tb/tb_error_tolerant_type2_sub32_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/error_tolerant_type2_sub32_pipe.sv
// Two-stage pipelined error-tolerant (type-2, block-speculative) subtractor.
// Each BLK-bit block takes its borrow-in from the zero-borrow-in borrow-out
// of the block just below it, so borrows never ripple across more than one
// block. Every result is compared with the exact difference. Results that
// differ are flagged and counted in a saturating counter.
//
// Handshake: a beat moves into a stage when that stage is empty or when its
// current content moves on in the same cycle. Input beats are accepted on
// valid_i && ready_o. Results are delivered on valid_o && ready_i. While
// valid_o is high and ready_i is low, the output registers hold.
module error_tolerant_type2_sub32_pipe #(
    parameter int WIDTH     = 32,
    parameter int BLK       = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     sub1_i,
    input  logic [WIDTH-1:0]     sub2_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH:0]       result_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    input  logic                 clr_cnt_i
);

    localparam int NB = WIDTH / BLK;

    // Stage-1 combinational terms
    logic [WIDTH-1:0] diff0_c;
    logic [WIDTH-1:0] diff1_c;
    logic [NB-1:0]    bz_c;
    logic [WIDTH:0]   exact_c;

    // Stage-1 registers
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] diff0_q, diff0_d;
    logic [WIDTH-1:0] diff1_q, diff1_d;
    logic [NB-1:0]    bz_q, bz_d;
    logic [WIDTH:0]   exact_q, exact_d;

    // Stage-2 combinational terms and registers
    logic [WIDTH-1:0] sel_c;
    logic [WIDTH:0]   result_c;
    logic             err_c;
    logic             v2_q, v2_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             err_q, err_d;

    // Error counter
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    // Handshake
    logic s1_adv;
    logic s2_adv;
    logic deliver;

    assign s2_adv  = !v2_q || ready_i;
    assign s1_adv  = !v1_q || s2_adv;
    assign deliver = v2_q && ready_i;

    assign ready_o   = s1_adv;
    assign valid_o   = v2_q;
    assign result_o  = result_q;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

    // Exact reference difference, kept with a zero-extended borrow position
    assign exact_c = {1'b0, sub1_i} - {1'b0, sub2_i};

    // Per-block differences for both possible borrow-ins, plus the
    // zero-borrow-in borrow-out that drives the next block's speculation
    for (genvar k = 0; k < NB; k++) begin : g_blk_s1
        logic [BLK:0] dz;
        assign dz = {1'b0, sub1_i[k*BLK +: BLK]} - {1'b0, sub2_i[k*BLK +: BLK]};
        assign diff0_c[k*BLK +: BLK] = dz[BLK-1:0];
        assign diff1_c[k*BLK +: BLK] = dz[BLK-1:0] - BLK'(1);
        assign bz_c[k] = dz[BLK];
    end

    // Per-block selection: block 0 always sees a zero borrow-in
    for (genvar k = 0; k < NB; k++) begin : g_blk_s2
        if (k == 0) begin : g_lsb
            assign sel_c[BLK-1:0] = diff0_q[BLK-1:0];
        end else begin : g_upper
            assign sel_c[k*BLK +: BLK] = bz_q[k-1] ? diff1_q[k*BLK +: BLK]
                                                   : diff0_q[k*BLK +: BLK];
        end
    end

    // The approximate borrow-out is the top block's zero-borrow-in borrow
    assign result_c = {bz_q[NB-1], sel_c};
    assign err_c    = (result_c != exact_q);

    // Stage-1 next state: load a new beat when accepted, drain when it moves on
    always_comb begin
        v1_d    = v1_q;
        diff0_d = diff0_q;
        diff1_d = diff1_q;
        bz_d    = bz_q;
        exact_d = exact_q;
        if (s1_adv) begin
            v1_d = valid_i;
            if (valid_i) begin
                diff0_d = diff0_c;
                diff1_d = diff1_c;
                bz_d    = bz_c;
                exact_d = exact_c;
            end
        end
    end

    // Stage-2 next state: take the stage-1 beat whenever the output is free
    always_comb begin
        v2_d     = v2_q;
        result_d = result_q;
        err_d    = err_q;
        if (s2_adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                result_d = result_c;
                err_d    = err_c;
            end
        end
    end

    // Saturating count of delivered errored beats; clear wins over a count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (deliver && err_q && (cnt_q != {ERR_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    // Pipeline and counter registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            diff0_q  <= '0;
            diff1_q  <= '0;
            bz_q     <= '0;
            exact_q  <= '0;
            v2_q     <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            diff0_q  <= diff0_d;
            diff1_q  <= diff1_d;
            bz_q     <= bz_d;
            exact_q  <= exact_d;
            v2_q     <= v2_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_error_tolerant_type2_sub32_pipe.sv
// Bench for error_tolerant_type2_sub32_pipe with a 2-bit error counter.
// The reference model computes the speculative difference block by block
// from operand comparisons. A queue of expected {err, result} beats tracks
// the pipeline contents.
module tb_error_tolerant_type2_sub32_pipe;

    localparam int WIDTH = 32;
    localparam int BLK   = 4;
    localparam int NB    = WIDTH / BLK;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk;
    logic             rst_ni;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] sub1_i;
    logic [WIDTH-1:0] sub2_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH:0]   result_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             clr_cnt_i;

    int total;
    int bad;
    int cyc;
    int obs_acc;
    int obs_del;
    logic [WIDTH+1:0] exp_q[$];
    int               tag_q[$];
    logic [CNT_W-1:0] cnt_m;

    error_tolerant_type2_sub32_pipe #(
        .WIDTH(WIDTH), .BLK(BLK), .ERR_CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .sub1_i(sub1_i), .sub2_i(sub2_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
        .clr_cnt_i(clr_cnt_i)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Speculative difference: block k borrows iff block k-1 alone has A < B
    function automatic logic [WIDTH:0] approx_diff(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        int unsigned ak, bk, bin;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            ak  = (a >> (BLK * k)) & 32'hF;
            bk  = (b >> (BLK * k)) & 32'hF;
            bin = 0;
            if (k > 0) begin
                if (((a >> (BLK * (k - 1))) & 32'hF) < ((b >> (BLK * (k - 1))) & 32'hF))
                    bin = 1;
            end
            r[BLK*k +: BLK] = 4'((ak - bk - bin) & 32'hF);
        end
        r[WIDTH] = (a[WIDTH-1:WIDTH-BLK] < b[WIDTH-1:WIDTH-BLK]);
        return r;
    endfunction

    function automatic logic [WIDTH+1:0] model_beat(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH:0] ap, ex;
        ap = approx_diff(a, b);
        ex = {1'b0, a} - {1'b0, b};
        return {(ap != ex), ap};
    endfunction

    // One clock cycle: drive, check against the model, advance the model
    task automatic step(input logic v, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic rdy,
                        input logic clr, output logic acc);
        logic rdy_m, vld_m, del;
        logic [WIDTH+1:0] head;
        valid_i   = v;
        sub1_i    = a;
        sub2_i    = b;
        ready_i   = rdy;
        clr_cnt_i = clr;
        #1;
        rdy_m = (exp_q.size() < 2) || rdy;
        vld_m = (exp_q.size() > 0) && (tag_q[0] <= cyc - 2);
        head  = (exp_q.size() > 0) ? exp_q[0] : '0;
        total++;
        if (ready_o !== rdy_m) begin
            bad++;
            $display("FAIL sb_ready_o cyc=%0d: got %b want %b", cyc, ready_o, rdy_m);
        end
        total++;
        if (valid_o !== vld_m) begin
            bad++;
            $display("FAIL sb_valid_o cyc=%0d: got %b want %b", cyc, valid_o, vld_m);
        end
        if (vld_m) begin
            total++;
            if ({err_o, result_o} !== head) begin
                bad++;
                $display("FAIL sb_beat cyc=%0d: got err=%b res=%h want err=%b res=%h",
                         cyc, err_o, result_o, head[WIDTH+1], head[WIDTH:0]);
            end
        end
        total++;
        if (err_cnt_o !== cnt_m) begin
            bad++;
            $display("FAIL sb_err_cnt cyc=%0d: got %0d want %0d", cyc, err_cnt_o, cnt_m);
        end
        if (valid_i && ready_o) obs_acc++;
        if (valid_o && ready_i) obs_del++;
        acc = v && rdy_m;
        del = vld_m && rdy;
        @(posedge clk);
        if (clr) cnt_m = '0;
        else if (del && head[WIDTH+1] && (cnt_m != CNT_MAX)) cnt_m = cnt_m + CNT_W'(1);
        if (del) begin
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back(model_beat(a, b));
            tag_q.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic clear_cnt();
        logic acc;
        step(1'b0, '0, '0, 1'b1, 1'b1, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d beats left want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b1; valid_i = 1'b0; ready_i = 1'b0; clr_cnt_i = 1'b0;
        sub1_i = '0; sub2_i = '0;
        #1 rst_ni = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
        total++;
        if (result_o !== 33'h0) begin bad++; $display("FAIL reset_result_o: got %h want 0", result_o); end
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err_o: got %b want 0", err_o); end
        total++;
        if (err_cnt_o !== 2'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_o); end
        total++;
        if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_o: got %b want 1", ready_o); end
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        exp_q.delete(); tag_q.delete(); cnt_m = '0; cyc = 0;
    endtask

    task automatic test_exact();
        logic acc;
        clear_cnt();
        step(1'b1, 32'h5, 32'h3, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (valid_o !== 1'b1 || result_o !== 33'h0_00000002 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL exact: got v=%b res=%h err=%b want v=1 res=000000002 err=0",
                     valid_o, result_o, err_o);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (err_cnt_o !== 2'd0) begin bad++; $display("FAIL exact_cnt: got %0d want 0", err_cnt_o); end
    endtask

    task automatic test_spec_miss();
        logic acc;
        clear_cnt();
        step(1'b1, 32'h100, 32'h1, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (valid_o !== 1'b1 || result_o !== 33'h0_000001FF || err_o !== 1'b1) begin
            bad++;
            $display("FAIL spec_miss: got v=%b res=%h err=%b want v=1 res=0000001ff err=1",
                     valid_o, result_o, err_o);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (err_cnt_o !== 2'd1) begin bad++; $display("FAIL spec_miss_cnt: got %0d want 1", err_cnt_o); end
    endtask

    task automatic test_borrow_out();
        logic acc;
        step(1'b1, 32'h0, 32'h1, 1'b1, 1'b0, acc);
        step(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, acc);
        total++;
        if (result_o !== 33'h0_000000FF || err_o !== 1'b1) begin
            bad++;
            $display("FAIL borrow_miss: got res=%h err=%b want res=0000000ff err=1", result_o, err_o);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (result_o !== 33'h0_FFFFFFFF || err_o !== 1'b0) begin
            bad++;
            $display("FAIL borrow_max: got res=%h err=%b want res=0ffffffff err=0", result_o, err_o);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [WIDTH-1:0] ba[4];
        logic [WIDTH-1:0] bb[4];
        int idx, acc0, del0, first, last, pre;
        for (int i = 0; i < 4; i++) begin ba[i] = $urandom; bb[i] = $urandom; end
        idx = 0; acc0 = obs_acc;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ba[idx], bb[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        total++;
        if (obs_acc - acc0 != 2) begin
            bad++;
            $display("FAIL bp_accepted: got %0d want 2", obs_acc - acc0);
        end
        total++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_stall: got ready_o=%b valid_o=%b want 0 1", ready_o, valid_o);
        end
        del0 = obs_del; first = -1; last = -1;
        for (int i = 0; i < 20 && (idx < 4 || exp_q.size() > 0); i++) begin
            logic [WIDTH-1:0] va, vb;
            va = (idx < 4) ? ba[idx] : '0;
            vb = (idx < 4) ? bb[idx] : '0;
            pre = obs_del;
            step((idx < 4), va, vb, 1'b1, 1'b0, acc);
            if (acc) idx++;
            if (obs_del != pre) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        total++;
        if (obs_del - del0 != 4) begin
            bad++;
            $display("FAIL bp_delivered: got %0d want 4", obs_del - del0);
        end
        total++;
        if (last - first != 3) begin
            bad++;
            $display("FAIL bp_gapless: got span %0d want 3", last - first);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        logic acc;
        clear_cnt();
        for (int i = 0; i < 6; i++) step(1'b1, 32'h100, 32'h1, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (err_cnt_o !== 2'd3) begin bad++; $display("FAIL sat_cnt: got %0d want 3", err_cnt_o); end
        total++;
        if (valid_o !== 1'b1 || err_o !== 1'b1) begin
            bad++;
            $display("FAIL sat_sixth: got v=%b err=%b want 1 1", valid_o, err_o);
        end
        step(1'b0, '0, '0, 1'b1, 1'b1, acc);
        total++;
        if (err_cnt_o !== 2'd0) begin bad++; $display("FAIL sat_clear: got %0d want 0", err_cnt_o); end
    endtask

    task automatic test_reset_midflight();
        logic acc;
        clear_cnt();
        step(1'b1, 32'h100, 32'h1, 1'b1, 1'b0, acc);
        step(1'b1, 32'h0, 32'h1, 1'b1, 1'b0, acc);
        drain();
        total++;
        if (err_cnt_o !== 2'd2) begin bad++; $display("FAIL mid_pre_cnt: got %0d want 2", err_cnt_o); end
        step(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, acc);
        step(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, acc);
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0 || err_o !== 1'b0 || result_o !== 33'h0) begin
            bad++;
            $display("FAIL mid_reset_out: got v=%b err=%b res=%h want 0 0 0", valid_o, err_o, result_o);
        end
        total++;
        if (err_cnt_o !== 2'd0) begin bad++; $display("FAIL mid_reset_cnt: got %0d want 0", err_cnt_o); end
        exp_q.delete(); tag_q.delete(); cnt_m = '0;
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        step(1'b1, 32'h7, 32'h2, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        total++;
        if (valid_o !== 1'b1 || result_o !== 33'h0_00000005 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_after: got v=%b res=%h err=%b want 1 000000005 0", valid_o, result_o, err_o);
        end
        drain();
    endtask

    task automatic test_random();
        logic acc, v, rdy, clr;
        logic [WIDTH-1:0] a, b;
        int mode;
        v = 1'b0; a = '0; b = '0;
        for (int i = 0; i < 400; i++) begin
            if (!v) begin
                mode = $urandom_range(0, 2);
                if (mode == 0) begin a = $urandom; b = $urandom; end
                else if (mode == 1) begin a = $urandom_range(0, 255); b = $urandom_range(0, 255); end
                else begin a = $urandom; b = a ^ (32'h1 << $urandom_range(0, 31)); end
                v = ($urandom_range(0, 3) != 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            step(v, a, b, rdy, clr, acc);
            if (acc) v = 1'b0;
        end
        drain();
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; obs_acc = 0; obs_del = 0; cnt_m = '0;
        test_reset();
        idle(1);
        test_exact();
        test_spec_miss();
        test_borrow_out();
        test_backpressure();
        test_saturation();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
